// File: rtl/fifo_sample_reader.sv
// Paced FIFO reader: every div_eff+1 cycles while enabled, pops one word from a
// FIFO and presents it as a held sample with a one-cycle valid pulse.
module fifo_sample_reader #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DIV_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clrh,
  input  logic                  enh,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  underrun,
  output logic [7:0]            underrun_cnt,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // FIFO handshake: fifo_rd is a single-cycle pop strobe, issued only when
  // fifo_empty was low at the tick; fifo_rdata is taken the cycle after the
  // strobe, with no backpressure in either direction.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

  state_t                 state_q;
  state_t                 state_d;
  logic [DIV_WIDTH-1:0]   cnt;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic                   armed;
  logic                   tick;
  logic                   do_capture;
  logic                   do_underrun;

  // Periods below 3 cycles would overlap a read in flight.
  assign div_eff = (div < DIV_MIN) ? DIV_MIN : div;

  // armed delays the first tick so it lands div_eff+1 cycles after enh rises.
  assign tick = enh && armed && (cnt == '0) && !clrh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clrh) begin
      cnt   <= div_eff;
      armed <= 1'b0;
    end else if (!enh || !armed) begin
      cnt   <= div_eff;
      armed <= enh;
    end else if (cnt == '0) begin
      cnt   <= div_eff;
    end else begin
      cnt   <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    do_capture  = 1'b0;
    do_underrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (!fifo_empty) begin
            state_d = READ;
          end else begin
            do_underrun = 1'b1;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d    = IDLE;
        do_capture = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A clear abandons any read in flight; its data is dropped.
    if (clrh) begin
      state_d     = IDLE;
      do_capture  = 1'b0;
      do_underrun = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= RESET_VALUE;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else if (clrh) begin
      sample       <= RESET_VALUE;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      sample_valid <= do_capture;
      if (do_capture) begin
        sample <= fifo_rdata;
      end
      if (do_underrun) begin
        underrun <= 1'b1;
        if (underrun_cnt != 8'hFF) begin
          underrun_cnt <= underrun_cnt + 8'd1;
        end
      end
    end
  end

  // Decoded straight from the state register so the strobe cannot glitch.
  assign fifo_rd   = (state_q == READ);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
